data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
Data-memory responder that sits at the far end of the pipeline memory stage's request interface. It accepts one read or write request, whose address, write data and byte strobes come from the memory stage. After a programmable wait latency it accesses an internal word-organised RAM and returns read data plus a one-cycle completion strobe. Illegal requests (misaligned, out of range, read and write together) complete with an error flag and do not touch memory.

Parameters:
DEPTH, 1024, number of 32-bit words in the RAM (power of two, 4..65536)
LATENCY, 2, wait cycles inserted before the access (0..15)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
read  input  1  read request strobe, level-sampled
write  input  1  write request strobe, level-sampled
memory_addr  input  32  byte address of the request
data_to_write  input  32  write data
byte_en  input  4  write byte-lane enables; bit i enables data_to_write[8i+7:8i]
read_data  output  32  data returned by the last successful read
ready  output  1  one-cycle completion pulse
addr_error  output  1  error status of the last completed request, valid when ready=1
busy  output  1  high whenever state is not IDLE

Behaviour:
- Clock is clk. Reset is rst: asynchronous and active-high.
- Reset values: state=IDLE, counter=0, read_data=0, ready=0, addr_error=0, busy=0. RAM contents are not cleared by reset.
- Word index = memory_addr[log2(DEPTH)+1:2].
- States: IDLE, WAIT, DONE.
- IDLE:
  - At an edge where read|write=1, latch the request: addr, data, byte_en, and kind (read, write or both).
  - Load counter=LATENCY and go to WAIT.
  - Request inputs are ignored in every state except IDLE.
- WAIT:
  - At each edge with counter!=0, counter decrements.
  - At the edge with counter==0, perform the access with the latched values and go to DONE.
  - Write: RAM lanes with byte_en[i]=1 are updated; other lanes are kept. byte_en=0000 is a legal no-op write.
  - Read: read_data is loaded with the full RAM word.
  - Error check (any one condition gives addr_error=1, no RAM change, read_data held):
    - addr[1:0]!=0
    - addr[31:2]>=DEPTH
    - read and write both set
- DONE:
  - ready=1 for exactly one cycle. addr_error is registered together with ready.
  - Next edge returns to IDLE with ready=0.
  - A request held high during DONE is accepted at the IDLE edge that follows.
- Latency: request sampled at edge E0 gives ready high in the cycle after edge E0+LATENCY+1. Minimum request spacing is LATENCY+3 cycles.
- read_data holds its value until the next successful read completes. Writes and errors do not change it.
- Reset during WAIT: the pending access is discarded and no RAM write occurs. Reset during DONE: a write already committed in WAIT stays committed.
- read/write held high continuously produce back-to-back transactions, each re-sampled in IDLE.

Test Plan:
- LATENCY=2. Write addr 0x10, data 0xDEADBEEF, byte_en=1111, then read 0x10 -> each completes 4 cycles after its sample edge. Read returns read_data=0xDEADBEEF, addr_error=0.
- Write 0x11223344 to 0x20 (byte_en=1111), then write 0xAABBCCDD with byte_en=0101, then read 0x20 -> read_data=0x11BB33DD.
- Read addr 0x22 (misaligned), then read 0x1000 with DEPTH=1024 (out of range) -> each gives ready=1 with addr_error=1, and read_data keeps its previous value.
- Assert read=1 and write=1 together at addr 0x30 -> ready=1, addr_error=1, and a later read of 0x30 returns the prior contents.
- Issue a write to 0x40 and assert rst during WAIT (LATENCY=4) -> busy=0 and ready=0 immediately. A later read of 0x40 returns the pre-write value.
- LATENCY=0, read held high for 9 cycles -> ready pulses every 3 cycles, busy low exactly one cycle between transactions.

Source files
------------

// File: rtl/data_memory_responder.sv
// Far-end data-memory responder: latches one request, waits LATENCY cycles,
// then accesses a word RAM and reports completion with an error flag.
//
// state | meaning
// IDLE  | waiting for a read/write strobe
// WAIT  | counting down the programmed latency, access on terminal count
// DONE  | one-cycle completion pulse on ready
module data_memory_responder #(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] memory_addr,
   input  logic [31:0] data_to_write,
   input  logic [3:0]  byte_en,
   output logic [31:0] read_data,
   output logic        ready,
   output logic        addr_error,
   output logic        busy
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [29:0] DEPTH_W = 30'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic [31:0] read_data_q, read_data_d;
   logic        ready_q, ready_d;
   logic        err_q, err_d;

   logic [31:0] mem_q [DEPTH];
   logic [AW-1:0] word_idx;
   logic          access_err;
   logic          mem_we;
   logic [31:0]   mem_rword;
   logic [31:0]   mem_wword;

   assign word_idx   = addr_q[AW+1:2];
   assign mem_rword  = mem_q[word_idx];
   assign access_err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= DEPTH_W) || (rd_q && wr_q);

   always_comb begin
      mem_wword = mem_rword;
      for (int i = 0; i < 4; i++) begin
         if (be_q[i]) begin
            mem_wword[8*i +: 8] = wdata_q[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      read_data_d = read_data_q;
      ready_d     = 1'b0;
      err_d       = err_q;
      mem_we      = 1'b0;
      case (state_q)
         IDLE: begin
            if (read || write) begin
               addr_d  = memory_addr;
               wdata_d = data_to_write;
               be_d    = byte_en;
               rd_d    = read;
               wr_d    = write;
               cnt_d   = 4'(LATENCY);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = DONE;
               ready_d = 1'b1;
               err_d   = access_err;
               if (!access_err) begin
                  mem_we = wr_q;
                  if (rd_q) begin
                     read_data_d = mem_rword;
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         be_q        <= 4'd0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         read_data_q <= 32'd0;
         ready_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         read_data_q <= read_data_d;
         ready_q     <= ready_d;
         err_q       <= err_d;
      end
   end

   // RAM is not reset; mem_we is derived from state_q so reset suppresses it.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[word_idx] <= mem_wword;
      end
   end

   assign read_data  = read_data_q;
   assign ready      = ready_q;
   assign addr_error = err_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench: three responders (LATENCY 2, 4, 0) driven by directed vectors.
module tb_data_memory_responder;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_0, read_0, write_0, ready_0, err_0, busy_0;
   logic [31:0] addr_0, wdata_0, rdata_0;
   logic [3:0]  be_0;
   logic        rst_1, read_1, write_1, ready_1, err_1, busy_1;
   logic [31:0] addr_1, wdata_1, rdata_1;
   logic [3:0]  be_1;
   logic        rst_2, read_2, write_2, ready_2, err_2, busy_2;
   logic [31:0] addr_2, wdata_2, rdata_2;
   logic [3:0]  be_2;

   data_memory_responder #(.DEPTH(1024), .LATENCY(2)) u0 (
      .clk(clk), .rst(rst_0), .read(read_0), .write(write_0), .memory_addr(addr_0),
      .data_to_write(wdata_0), .byte_en(be_0), .read_data(rdata_0), .ready(ready_0),
      .addr_error(err_0), .busy(busy_0));
   data_memory_responder #(.DEPTH(1024), .LATENCY(4)) u1 (
      .clk(clk), .rst(rst_1), .read(read_1), .write(write_1), .memory_addr(addr_1),
      .data_to_write(wdata_1), .byte_en(be_1), .read_data(rdata_1), .ready(ready_1),
      .addr_error(err_1), .busy(busy_1));
   data_memory_responder #(.DEPTH(1024), .LATENCY(0)) u2 (
      .clk(clk), .rst(rst_2), .read(read_2), .write(write_2), .memory_addr(addr_2),
      .data_to_write(wdata_2), .byte_en(be_2), .read_data(rdata_2), .ready(ready_2),
      .addr_error(err_2), .busy(busy_2));

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];
   exp_t e0, e1, e2;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_in(input int idx, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      case (idx)
         0: begin read_0 = rd; write_0 = wr; addr_0 = a; wdata_0 = d; be_0 = be; end
         1: begin read_1 = rd; write_1 = wr; addr_1 = a; wdata_1 = d; be_1 = be; end
         default: begin read_2 = rd; write_2 = wr; addr_2 = a; wdata_2 = d; be_2 = be; end
      endcase
   endtask

   function automatic logic get_busy(input int idx);
      case (idx)
         0: return busy_0;
         1: return busy_1;
         default: return busy_2;
      endcase
   endfunction

   function automatic logic get_ready(input int idx);
      case (idx)
         0: return ready_0;
         1: return ready_1;
         default: return ready_2;
      endcase
   endfunction

   task automatic push(input int idx, input logic [31:0] d, input logic e);
      exp_t x;
      x.data = d;
      x.err  = e;
      case (idx)
         0: q0.push_back(x);
         1: q1.push_back(x);
         default: q2.push_back(x);
      endcase
   endtask

   task automatic wait_idle(input int idx);
      int n;
      n = 0;
      @(negedge clk);
      while (get_busy(idx) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (get_busy(idx)) begin
         n_cmp++;
         n_bad++;
         $display("FAIL u%0d idle timeout: busy=1 expected 0", idx);
      end
   endtask

   // One transaction; checks completion arrives lat+2 negedges after the sample edge.
   task automatic issue(input int idx, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        input logic [31:0] exp_d, input logic exp_e, input int lat);
      bit seen;
      seen = 1'b0;
      wait_idle(idx);
      push(idx, exp_d, exp_e);
      set_in(idx, rd, wr, a, d, be);
      @(posedge clk);
      @(negedge clk);
      set_in(idx, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      for (int k = 1; k <= 30; k++) begin
         if (k > 1) @(negedge clk);
         if (get_ready(idx)) begin
            check($sformatf("u%0d latency a=%h", idx, a), 32'(k), 32'(lat + 2));
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL u%0d ready timeout a=%h: ready=0 expected 1", idx, a);
      end
   endtask

   always @(negedge clk) begin
      if (ready_0 === 1'b1) begin
         if (q0.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL u0 unexpected ready: got 1 expected no pending request");
         end else begin
            e0 = q0.pop_front();
            check("u0 read_data", rdata_0, e0.data);
            check("u0 addr_error", {31'd0, err_0}, {31'd0, e0.err});
         end
      end
   end

   always @(negedge clk) begin
      if (ready_1 === 1'b1) begin
         if (q1.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL u1 unexpected ready: got 1 expected no pending request");
         end else begin
            e1 = q1.pop_front();
            check("u1 read_data", rdata_1, e1.data);
            check("u1 addr_error", {31'd0, err_1}, {31'd0, e1.err});
         end
      end
   end

   always @(negedge clk) begin
      if (ready_2 === 1'b1) begin
         if (q2.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL u2 unexpected ready: got 1 expected no pending request");
         end else begin
            e2 = q2.pop_front();
            check("u2 read_data", rdata_2, e2.data);
            check("u2 addr_error", {31'd0, err_2}, {31'd0, e2.err});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      rst_0 = 1'b1; rst_1 = 1'b1; rst_2 = 1'b1;
      for (int i = 0; i < 3; i++) set_in(i, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      repeat (2) @(negedge clk);
      check("u0 reset read_data", rdata_0, 32'd0);
      check("u0 reset ready/err/busy", {29'd0, ready_0, err_0, busy_0}, 32'd0);
      check("u1 reset ready/err/busy", {29'd0, ready_1, err_1, busy_1}, 32'd0);
      check("u2 reset ready/err/busy", {29'd0, ready_2, err_2, busy_2}, 32'd0);
      rst_0 = 1'b0; rst_1 = 1'b0; rst_2 = 1'b0;

      // LATENCY=2: basic, byte lanes, errors, last word, no-op write
      issue(0, 0, 1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h00000000, 0, 2);
      issue(0, 1, 0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 0, 2);
      issue(0, 0, 1, 32'h20,   32'h11223344, 4'hF, 32'hDEADBEEF, 0, 2);
      issue(0, 0, 1, 32'h20,   32'hAABBCCDD, 4'h5, 32'hDEADBEEF, 0, 2);
      issue(0, 1, 0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 0, 2);
      issue(0, 1, 0, 32'h22,   32'h0,        4'h0, 32'h11BB33DD, 1, 2);
      issue(0, 1, 0, 32'h1000, 32'h0,        4'h0, 32'h11BB33DD, 1, 2);
      issue(0, 0, 1, 32'h30,   32'h0BADC0DE, 4'hF, 32'h11BB33DD, 0, 2);
      issue(0, 1, 1, 32'h30,   32'hFFFFFFFF, 4'hF, 32'h11BB33DD, 1, 2);
      issue(0, 1, 0, 32'h30,   32'h0,        4'h0, 32'h0BADC0DE, 0, 2);
      issue(0, 0, 1, 32'hFFC,  32'h600DF00D, 4'hF, 32'h0BADC0DE, 0, 2);
      issue(0, 0, 1, 32'hFFC,  32'h00000000, 4'h0, 32'h0BADC0DE, 0, 2);
      issue(0, 1, 0, 32'hFFC,  32'h0,        4'h0, 32'h600DF00D, 0, 2);

      // LATENCY=4: reset while a write is pending in WAIT
      issue(1, 0, 1, 32'h40, 32'h55AA55AA, 4'hF, 32'h00000000, 0, 4);
      wait_idle(1);
      set_in(1, 1'b0, 1'b1, 32'h40, 32'h12345678, 4'hF);
      @(posedge clk);
      @(negedge clk);
      set_in(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      @(negedge clk);
      rst_1 = 1'b1;
      #1;
      check("u1 busy after rst in WAIT", {31'd0, busy_1}, 32'd0);
      check("u1 ready after rst in WAIT", {31'd0, ready_1}, 32'd0);
      @(negedge clk);
      rst_1 = 1'b0;
      repeat (6) @(negedge clk);
      check("u1 no late ready/busy", {30'd0, ready_1, busy_1}, 32'd0);
      issue(1, 1, 0, 32'h40, 32'h0, 4'h0, 32'h55AA55AA, 0, 4);

      // LATENCY=0: read held high for 9 cycles
      issue(2, 0, 1, 32'h10, 32'hCAFEF00D, 4'hF, 32'h00000000, 0, 0);
      wait_idle(2);
      for (int i = 0; i < 3; i++) push(2, 32'hCAFEF00D, 1'b0);
      set_in(2, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      pulses = 0;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 9) set_in(2, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
         check($sformatf("u2 busy k=%0d", k), {31'd0, busy_2}, {31'd0, (k % 3) != 0});
         check($sformatf("u2 ready k=%0d", k), {31'd0, ready_2}, {31'd0, (k % 3) == 2});
         if (ready_2) pulses++;
      end
      check("u2 ready pulse count", 32'(pulses), 32'd3);

      repeat (5) @(negedge clk);
      check("u0 pending left", 32'(q0.size()), 32'd0);
      check("u1 pending left", 32'(q1.size()), 32'd0);
      check("u2 pending left", 32'(q2.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
